uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo.sv | 66 ++++++
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and baud helper for the UART transmitter
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Clock cycles per serial bit; integer truncation is intentional.
  function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte buffer in front of the serializer
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];

  // Data storage carries no reset; only the pointers and count decide validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8-bit MSB-first UART serializer
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
  end

  localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  uart_tx_state_t                 state_q, state_d;
  logic [UART_DATA_BITS-1:0]      shift_q, shift_d;
  logic [BIT_W-1:0]               bit_q, bit_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           tx_q, tx_d;
  logic                           fifo_push;
  logic                           fifo_pop;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [UART_DATA_BITS-1:0]      fifo_head;

  // A full FIFO refuses new bytes even if a pop frees a slot this cycle.
  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && !fifo_full;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state logic; tx_d is the line level for the cycle after this edge.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        bit_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[UART_DATA_BITS-1];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
          tx_d  = 1'b0;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {shift_q[UART_DATA_BITS-2:0], 1'b0};
            tx_d    = shift_q[UART_DATA_BITS-2];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          tx_d  = shift_q[UART_DATA_BITS-1];
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          tx_d  = 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State, shifter and counters; reset drives the line high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

  localparam int CLK_FREQ_HZ = 1_000_000;
  localparam int BAUD        = 100_000;
  localparam int FIFO_DEPTH  = 4;
  localparam int CPB         = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         acc;
  int         lows;
  logic       txlog [0:4095];
  logic [7:0] exp_bytes [0:7];

  uart_tx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < 4096) txlog[cyc] = tx;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic verify_frames(input int start, input int n);
    logic       expbit;
    logic [7:0] dec;
    int         f;
    int         p;
    check("pre_start_idle", {31'b0, txlog[start-1]}, 32'd1);
    for (int k = 0; k < n * 100; k++) begin
      f = k / 100;
      p = (k % 100) / CPB;
      if (p == 0)      expbit = 1'b0;
      else if (p == 9) expbit = 1'b1;
      else             expbit = exp_bytes[f][8-p];
      check($sformatf("frame%0d_cyc%0d", f, k % 100), {31'b0, txlog[start+k]}, {31'b0, expbit});
    end
    for (int fr = 0; fr < n; fr++) begin
      dec = 8'h00;
      for (int b = 0; b < 8; b++) begin
        dec = {dec[6:0], txlog[start + fr*100 + (b+1)*CPB + CPB/2]};
      end
      check($sformatf("decode%0d", fr), {24'b0, dec}, {24'b0, exp_bytes[fr]});
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_ready", {31'b0, tx_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_count", {29'b0, fifo_count}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_tx", {31'b0, tx}, 32'd1);
    check("idle_busy", {31'b0, busy}, 32'd0);

    // single byte 0xA5
    exp_bytes[0] = 8'hA5;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick(); acc = cyc; tx_valid = 1'b0;
    check("t1_count", {29'b0, fifo_count}, 32'd1);
    check("t1_tx_before", {31'b0, tx}, 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd1);
    tick();
    check("t1_fall", {31'b0, tx}, 32'd0);
    repeat (99) tick();
    check("t1_busy_stop", {31'b0, busy}, 32'd1);
    tick();
    check("t1_busy_end", {31'b0, busy}, 32'd0);
    check("t1_tx_end", {31'b0, tx}, 32'd1);
    verify_frames(acc + 1, 1);

    // three bytes back to back
    exp_bytes[0] = 8'h00; exp_bytes[1] = 8'hFF; exp_bytes[2] = 8'h3C;
    tx_data = 8'h00; tx_valid = 1'b1;
    tick(); acc = cyc; tx_data = 8'hFF;
    tick(); tx_data = 8'h3C;
    tick(); tx_valid = 1'b0;
    check("t2_count", {29'b0, fifo_count}, 32'd2);
    repeat (298) tick();
    check("t2_busy_last", {31'b0, busy}, 32'd1);
    tick();
    check("t2_busy_end", {31'b0, busy}, 32'd0);
    verify_frames(acc + 1, 3);

    // six bytes offered while idle; also full-with-pop on the same edge
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
    exp_bytes[3] = 8'h44; exp_bytes[4] = 8'h55; exp_bytes[5] = 8'h66;
    tx_data = 8'h11; tx_valid = 1'b1;
    tick(); acc = cyc; tx_data = 8'h22;
    tick(); tx_data = 8'h33;
    tick(); tx_data = 8'h44;
    tick(); tx_data = 8'h55;
    tick(); tx_data = 8'h66;
    check("t3_full_count", {29'b0, fifo_count}, 32'd4);
    check("t3_full_ready", {31'b0, tx_ready}, 32'd0);
    repeat (96) tick();
    check("t3_hold_count", {29'b0, fifo_count}, 32'd4);
    check("t3_hold_ready", {31'b0, tx_ready}, 32'd0);
    tick();
    check("t3_pop_count", {29'b0, fifo_count}, 32'd3);
    check("t3_pop_ready", {31'b0, tx_ready}, 32'd1);
    tick(); tx_valid = 1'b0;
    check("t3_refill_count", {29'b0, fifo_count}, 32'd4);
    check("t3_refill_ready", {31'b0, tx_ready}, 32'd0);
    repeat (498) tick();
    check("t3_busy_last", {31'b0, busy}, 32'd1);
    tick();
    check("t3_busy_end", {31'b0, busy}, 32'd0);
    check("t3_count_end", {29'b0, fifo_count}, 32'd0);
    verify_frames(acc + 1, 6);

    // reset in the middle of a 0x81 frame with a byte still buffered
    tx_data = 8'h81; tx_valid = 1'b1;
    tick(); acc = cyc; tx_data = 8'h42;
    tick(); tx_valid = 1'b0;
    repeat (45) tick();
    check("t4_tx_mid", {31'b0, tx}, 32'd0);
    check("t4_count_mid", {29'b0, fifo_count}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_tx", {31'b0, tx}, 32'd1);
    check("t4_rst_count", {29'b0, fifo_count}, 32'd0);
    check("t4_rst_busy", {31'b0, busy}, 32'd0);
    check("t4_rst_ready", {31'b0, tx_ready}, 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("t4_no_fall", lows, 32'd0);
    check("t4_count_after", {29'b0, fifo_count}, 32'd0);
    check("t4_busy_after", {31'b0, busy}, 32'd0);

    // recovery after reset
    exp_bytes[0] = 8'h5A;
    tx_data = 8'h5A; tx_valid = 1'b1;
    tick(); acc = cyc; tx_valid = 1'b0;
    repeat (101) tick();
    check("t5_busy_end", {31'b0, busy}, 32'd0);
    verify_frames(acc + 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
